regfile_reader: RTL and testbench
=================================

# regfile_reader

Read side of the pipelined CPU's 64-bit, 32-entry register file. Accepts decode-stage operand requests over a valid/ready handshake and returns both source operands one cycle later. Reads the storage array's parallel outputs, bypasses same-cycle writeback data, and keeps a pending-write scoreboard that stalls requests on RAW/WAW hazards. X31 always reads zero and is never pending.

## Interface
- DW, 64, data width of each register
- NREG, 32, number of architectural registers; index NREG-1 (X31) is hard zero
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- regs  in  DW x NREG (unpacked array)  current contents of the storage array
- req_valid  in  1  operand request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_ra  in  5  source register A
- req_rb  in  5  source register B
- req_rd  in  5  destination register of the requesting instruction
- req_rd_we  in  1  instruction will write req_rd
- wb_valid  in  1  writeback this cycle; storage is updated on the same clk edge
- wb_rd  in  5  writeback destination
- wb_data  in  DW  writeback value
- rsp_valid  out  1  operand pair valid
- rsp_a  out  DW  operand for req_ra
- rsp_b  out  DW  operand for req_rb
- rsp_ready  in  1  consumer takes the operand pair
- stall_cnt  out  16  hazard-stall cycle counter, saturating

## Operation
- Scoreboard `pending[NREG-1:0]`: one bit per register. Bit 31 is constant 0.
- Operand source for index r, evaluated in priority order:
  - r == 31 gives 0.
  - wb_valid && wb_rd == r gives wb_data (bypass).
  - Otherwise regs[r].
- clear(r) = wb_valid && wb_rd == r.
- Hazard, evaluated only when req_valid is high:
  - RAW: (pending[ra] && !clear(ra)) or (pending[rb] && !clear(rb)).
  - WAW: req_rd_we && req_rd != 31 && pending[rd] && !clear(rd).
- req_ready = !hazard && (!rsp_valid || rsp_ready). This is purely combinational; no dependence on req_valid beyond the hazard term.
- On accept:
  - Latch operands into rsp_a/rsp_b and set rsp_valid.
  - If req_rd_we && req_rd != 31, set pending[req_rd].
- Writeback: clears pending[wb_rd]. A writeback to a non-pending register, or to X31, is legal and only updates storage.
- Same-cycle accept that sets bit r and writeback that clears bit r: set wins, and the bit stays 1.
- Response register:
  - rsp_valid clears on rsp_ready when no new accept occurs.
  - Accept plus rsp_ready in the same cycle: back-to-back, and rsp_valid stays 1 with new data.
  - While rsp_valid && !rsp_ready, rsp_a/rsp_b hold steady even if storage changes.
- stall_cnt: increments each cycle with req_valid && hazard. It saturates at 0xFFFF.

## Timing
- Reset (async assert, sync-safe deassert):
  - pending = 0, rsp_valid = 0, rsp_a = rsp_b = 0, stall_cnt = 0.
  - req_ready = 1 out of reset.
- Latency: accept at edge N gives rsp_valid high after edge N; data equals operand sources sampled in the cycle before edge N.
- Throughput: one request per cycle when rsp_ready is held high and there are no hazards.
- A stalled request resolves in the same cycle its blocking writeback arrives, using bypassed data. There is no extra bubble.
- Reset mid-operation discards the in-flight response and all scoreboard state immediately.

## Test plan
- Reset then idle:
  - After reset, rsp_valid = 0, stall_cnt = 0, req_ready = 1.
  - Request ra = 3, rb = 31 with regs[3] = 0x1234 gives rsp_a = 0x1234 and rsp_b = 0 one cycle later.
- RAW stall and bypass:
  - Accept rd = 5 (we = 1); next request has ra = 5. req_ready = 0 and stall_cnt increments each cycle.
  - Then wb_valid, wb_rd = 5, wb_data = 0xDEAD gives accept that cycle with rsp_a = 0xDEAD, and pending[5] clears.
- WAW plus set/clear collision:
  - With pending[7] = 1, a request with rd = 7 stalls.
  - The same request together with wb_rd = 7 is accepted, and pending[7] remains 1.
- Backpressure:
  - Hold rsp_ready = 0 for 3 cycles gives req_ready = 0, and rsp_a/rsp_b are unchanged when regs change.
  - Raise rsp_ready with req_valid high gives back-to-back transfer, and rsp_valid stays 1.
- X31 rules: rd = 31 with we = 1 never sets pending; a following ra = 31 gives no stall and rsp_a = 0.
- Saturation and async reset:
  - Force 70000 hazard cycles gives stall_cnt = 0xFFFF.
  - Assert reset mid-response gives all outputs zeroed immediately without waiting for clk.

Source files
------------

// File: rtl/regfile_reader.sv
// Read side of the 64-bit x 32 register file: operand fetch with writeback bypass,
// a pending-write scoreboard that stalls RAW/WAW hazards, and a one-deep response register.
module regfile_reader #(
    parameter int DW   = 64,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] regs [NREG],
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_ra,
    input  logic [4:0]    req_rb,
    input  logic [4:0]    req_rd,
    input  logic          req_rd_we,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_a,
    output logic [DW-1:0] rsp_b,
    input  logic          rsp_ready,
    output logic [15:0]   stall_cnt
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the operand pair transfers on a rising edge where rsp_valid && rsp_ready.
    localparam logic [4:0] ZERO_REG = 5'(NREG - 1);

    logic [NREG-1:0] pending_q, pending_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_a_q, rsp_a_d;
    logic [DW-1:0]   rsp_b_q, rsp_b_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    logic [DW-1:0]   op_a, op_b;
    logic            blk_a, blk_b, blk_d;
    logic            hazard, accept;

    always_comb begin
        op_a = regs[req_ra];
        if (wb_valid && wb_rd == req_ra) op_a = wb_data;
        if (req_ra == ZERO_REG) op_a = '0;
        op_b = regs[req_rb];
        if (wb_valid && wb_rd == req_rb) op_b = wb_data;
        if (req_rb == ZERO_REG) op_b = '0;
    end

    // A pending bit being cleared this cycle no longer blocks: the bypass supplies the data.
    always_comb begin
        blk_a     = pending_q[req_ra] && !(wb_valid && wb_rd == req_ra);
        blk_b     = pending_q[req_rb] && !(wb_valid && wb_rd == req_rb);
        blk_d     = req_rd_we && (req_rd != ZERO_REG) && pending_q[req_rd]
                    && !(wb_valid && wb_rd == req_rd);
        hazard    = req_valid && (blk_a || blk_b || blk_d);
        req_ready = !hazard && (!rsp_valid_q || rsp_ready);
        accept    = req_valid && req_ready;
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_rd] = 1'b0;
        // Applied after the clear so a same-cycle set on the same register wins.
        if (accept && req_rd_we && req_rd != ZERO_REG) pending_d[req_rd] = 1'b1;
        pending_d[ZERO_REG] = 1'b0;

        rsp_valid_d = rsp_valid_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_a_d     = op_a;
            rsp_b_d     = op_b;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: directed vector table, hand-written saturation/reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_regfile_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] regs [32];
    logic        req_valid, req_ready;
    logic [4:0]  req_ra, req_rb, req_rd;
    logic        req_rd_we;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        rsp_valid;
    logic [63:0] rsp_a, rsp_b;
    logic        rsp_ready;
    logic [15:0] stall_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_reader dut (
        .clk       (clk),
        .reset     (reset),
        .regs      (regs),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rd    (req_rd),
        .req_rd_we (req_rd_we),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rsp_valid (rsp_valid),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .rsp_ready (rsp_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic we, input logic wbv,
                         input logic [4:0] wbrd, input logic [63:0] wbd, input logic rr);
        req_valid = rv; req_ra = ra; req_rb = rb; req_rd = rd; req_rd_we = we;
        wb_valid = wbv; wb_rd = wbrd; wb_data = wbd; rsp_ready = rr;
    endtask

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = 64'h100 + 64'(i);
        regs[3]  = 64'h1234;
        regs[31] = 64'hBAD;
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [63:0] a; logic [63:0] b; } pair_t;
    logic [4:0] outst[$];
    pair_t      rsp_q[$];
    int         stalls;

    task automatic model_reset();
        outst.delete();
        rsp_q.delete();
        stalls = 0;
    endtask

    function automatic bit in_flight(input logic [4:0] r);
        foreach (outst[i]) if (outst[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit waiting(input logic [4:0] r);
        return (r != 5'd31) && in_flight(r) && !(wb_valid && wb_rd == r);
    endfunction

    function automatic logic [63:0] value(input logic [4:0] r);
        if (r == 5'd31) return 64'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return regs[r];
    endfunction

    task automatic model_cycle();
        bit          haz, exp_rdy, acc, wbv, set_rd;
        logic [4:0]  wbrd, rd;
        logic [63:0] wbd;
        pair_t       p;
        #3;
        haz     = req_valid && (waiting(req_ra) || waiting(req_rb) || (req_rd_we && waiting(req_rd)));
        exp_rdy = !haz && (rsp_q.size() == 0 || rsp_ready);
        check("rnd_req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
        acc    = req_valid && exp_rdy;
        p.a    = value(req_ra);
        p.b    = value(req_rb);
        wbv    = wb_valid; wbrd = wb_rd; wbd = wb_data;
        rd     = req_rd;
        set_rd = acc && req_rd_we && req_rd != 5'd31;
        @(posedge clk);
        #1;
        if (rsp_ready && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (acc) rsp_q.push_back(p);
        if (wbv) begin
            for (int i = outst.size() - 1; i >= 0; i--) if (outst[i] == wbrd) outst.delete(i);
            regs[wbrd] = wbd;
        end
        if (set_rd) outst.push_back(rd);
        if (haz) stalls++;
        check("rnd_rsp_valid", {63'd0, rsp_valid}, {63'd0, rsp_q.size() != 0});
        if (rsp_q.size() != 0) begin
            check("rnd_rsp_a", rsp_a, rsp_q[0].a);
            check("rnd_rsp_b", rsp_b, rsp_q[0].b);
        end
        check("rnd_stall_cnt", {48'd0, stall_cnt}, (stalls > 65535) ? 64'hFFFF : 64'(stalls));
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 7) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rv;  logic [4:0] ra; logic [4:0] rb; logic [4:0] rd; logic we;
        logic        wbv; logic [4:0] wbrd; logic [63:0] wbd; logic rr;
        logic        e_rdy; logic e_rv; logic [63:0] e_a; logic [63:0] e_b; logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [4:0] rd, input logic we, input logic wbv,
                                input logic [4:0] wbrd, input logic [63:0] wbd, input logic rr,
                                input logic e_rdy, input logic e_rv, input logic [63:0] e_a,
                                input logic [63:0] e_b, input logic [15:0] e_stall);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rb = rb; v.rd = rd; v.we = we;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.rr = rr;
        v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_a = e_a; v.e_b = e_b; v.e_stall = e_stall;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        //            rv ra  rb  rd  we wbv wbrd wbd       rr  rdy rv  a         b         stall
        tbl[0]  = mk(0, 0,  0,  0,  0, 0,  0,  64'h0,     1,  1,  0,  64'h0,    64'h0,    16'd0);
        tbl[1]  = mk(1, 3,  31, 0,  0, 0,  0,  64'h0,     1,  1,  1,  64'h1234, 64'h0,    16'd0);
        tbl[2]  = mk(1, 1,  2,  5,  1, 0,  0,  64'h0,     1,  1,  1,  64'h101,  64'h102,  16'd0);
        tbl[3]  = mk(1, 5,  0,  0,  0, 0,  0,  64'h0,     1,  0,  0,  64'h0,    64'h0,    16'd1);
        tbl[4]  = mk(1, 5,  0,  0,  0, 0,  0,  64'h0,     1,  0,  0,  64'h0,    64'h0,    16'd2);
        tbl[5]  = mk(1, 5,  0,  0,  0, 1,  5,  64'hDEAD,  1,  1,  1,  64'hDEAD, 64'h100,  16'd2);
        tbl[6]  = mk(1, 5,  5,  7,  1, 0,  0,  64'h0,     1,  1,  1,  64'hDEAD, 64'hDEAD, 16'd2);
        tbl[7]  = mk(1, 1,  2,  7,  1, 0,  0,  64'h0,     1,  0,  0,  64'h0,    64'h0,    16'd3);
        tbl[8]  = mk(1, 1,  2,  7,  1, 1,  7,  64'hBEEF,  1,  1,  1,  64'h101,  64'h102,  16'd3);
        tbl[9]  = mk(1, 7,  0,  0,  0, 0,  0,  64'h0,     1,  0,  0,  64'h0,    64'h0,    16'd4);
        tbl[10] = mk(0, 0,  0,  0,  0, 1,  7,  64'h77,    1,  1,  0,  64'h0,    64'h0,    16'd4);
        tbl[11] = mk(1, 7,  3,  0,  0, 0,  0,  64'h0,     0,  1,  1,  64'h77,   64'h1234, 16'd4);
        tbl[12] = mk(1, 1,  2,  0,  0, 1,  7,  64'h99,    0,  0,  1,  64'h77,   64'h1234, 16'd4);
        tbl[13] = mk(1, 1,  2,  0,  0, 1,  3,  64'h55,    0,  0,  1,  64'h77,   64'h1234, 16'd4);
        tbl[14] = mk(1, 1,  2,  0,  0, 0,  0,  64'h0,     0,  0,  1,  64'h77,   64'h1234, 16'd4);
        tbl[15] = mk(1, 7,  3,  0,  0, 0,  0,  64'h0,     1,  1,  1,  64'h99,   64'h55,   16'd4);
        tbl[16] = mk(1, 1,  1,  31, 1, 0,  0,  64'h0,     1,  1,  1,  64'h101,  64'h101,  16'd4);
        tbl[17] = mk(1, 31, 31, 0,  0, 1,  31, 64'hFFFF,  1,  1,  1,  64'h0,    64'h0,    16'd4);
        tbl[18] = mk(0, 0,  0,  0,  0, 0,  0,  64'h0,     1,  1,  0,  64'h0,    64'h0,    16'd4);

        // clock/reset
        init_regs();
        drive(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // directed table: each row is one clock cycle
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rv, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].we,
                  tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].rr);
            #3;
            check($sformatf("vec%0d_req_ready", i), {63'd0, req_ready}, {63'd0, tbl[i].e_rdy});
            @(posedge clk);
            #1;
            if (tbl[i].wbv) regs[tbl[i].wbrd] = tbl[i].wbd;
            check($sformatf("vec%0d_rsp_valid", i), {63'd0, rsp_valid}, {63'd0, tbl[i].e_rv});
            if (tbl[i].e_rv || i == 0) begin
                check($sformatf("vec%0d_rsp_a", i), rsp_a, tbl[i].e_a);
                check($sformatf("vec%0d_rsp_b", i), rsp_b, tbl[i].e_b);
            end
            check($sformatf("vec%0d_stall_cnt", i), {48'd0, stall_cnt}, {48'd0, tbl[i].e_stall});
        end

        // saturation: park a response, then hold a RAW hazard for 70000 cycles
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 64'h0, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        init_regs();
        drive(1, 0, 0, 9, 1, 0, 0, 64'h0, 0);
        @(posedge clk);
        #1 drive(1, 9, 0, 0, 0, 0, 0, 64'h0, 0);
        repeat (70000) @(posedge clk);
        #1;
        check("sat_stall_cnt", {48'd0, stall_cnt}, 64'hFFFF);
        check("sat_req_ready", {63'd0, req_ready}, 64'd0);
        check("sat_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk);
        #1 check("sat_hold", {48'd0, stall_cnt}, 64'hFFFF);

        // asynchronous reset in mid-cycle, no clock edge in between
        #2 reset = 1'b0;
        #1;
        check("areset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("areset_rsp_a", rsp_a, 64'd0);
        check("areset_rsp_b", rsp_b, 64'd0);
        check("areset_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        check("areset_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;

        // randomized traffic against the reference model
        init_regs();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wr;
            if (outst.size() > 0 && $urandom_range(0, 1) == 1)
                wr = outst[$urandom_range(0, outst.size() - 1)];
            else
                wr = pick_reg();
            drive($urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, wr,
                  {$urandom, $urandom}, $urandom_range(0, 3) != 0);
            model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
